// File: rtl/jt12_wr_sched_if.sv
// Bus bundle for the jt12 write scheduler: the request handshake on one side
// and the jt12 CPU port on the other. The scheduler is the slave; whatever
// drives requests and models the jt12 is the master.
interface jt12_wr_sched_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_part;
    logic [7:0] req_reg;
    logic [7:0] req_val;
    logic       ym_cs_n;
    logic       ym_wr_n;
    logic [1:0] ym_addr;
    logic [7:0] ym_din;
    logic [7:0] ym_dout;

    modport master (
        output req_valid, req_part, req_reg, req_val, ym_dout,
        input  req_ready, ym_cs_n, ym_wr_n, ym_addr, ym_din
    );

    modport slave (
        input  req_valid, req_part, req_reg, req_val, ym_dout,
        output req_ready, ym_cs_n, ym_wr_n, ym_addr, ym_din
    );
endinterface

// File: rtl/jt12_wr_sched.sv
// Queued register-write scheduler for the jt12 CPU bus. Each queued
// {part, reg, value} triple becomes an address write, a data write and a
// busy-flag poll. The FIFO runs every clock; the bus sequencer only on cen.
module jt12_wr_sched #(
    parameter int FIFO_AW  = 4,
    parameter int WR_CYC   = 2,
    parameter int BUSY_TMO = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             flush,
    jt12_wr_sched_if.slave   bus,
    output logic [FIFO_AW:0] level,
    output logic             active,
    output logic             tmo_err
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
    localparam int PW    = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;

    typedef enum logic [2:0] {IDLE, AWR, AGAP, DWR, DGAP, POLL} state_t;

    // FIFO storage: {part, reg, val}
    logic [16:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               push, pop;
    logic [16:0]        head;

    state_t      state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic        settle_q, settle_d;
    logic [16:0] hold_q, hold_d;
    logic        cs_q, cs_d, wr_q, wr_d, tmo_q, tmo_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        unused_dout;

    assign unused_dout   = &{1'b0, bus.ym_dout[6:0]};
    assign bus.req_ready = level_q < (FIFO_AW+1)'(DEPTH);
    // a flush in the same cycle wins over a push
    assign push          = bus.req_valid && bus.req_ready && !flush;
    assign pop           = cen && (state_q == IDLE) && (level_q != '0);
    assign head          = mem_q[rptr_q];

    assign bus.ym_cs_n = cs_q;
    assign bus.ym_wr_n = wr_q;
    assign bus.ym_addr = addr_q;
    assign bus.ym_din  = din_q;
    assign level       = level_q;
    assign active      = (state_q != IDLE) || (level_q != '0);
    assign tmo_err     = tmo_q;

    // FIFO payload write; contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {bus.req_part, bus.req_reg, bus.req_val};
    end

    // occupancy: flush empties the queue but leaves the in-flight entry alone
    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
        if (flush)             level_d = '0;
    end

    // FIFO pointers and level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (flush)    rptr_q <= wptr_q;
            else if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

    // bus sequencer: outputs are computed alongside the next state so the
    // registered bus always matches the state being entered
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pcnt_d   = pcnt_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        cs_d     = cs_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        din_d    = din_q;
        tmo_d    = tmo_q;
        if (cen) begin
            case (state_q)
                IDLE: if (level_q != '0) begin
                    hold_d  = head;
                    state_d = AWR;
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = {head[16], 1'b0};
                    din_d   = head[15:8];
                    wcnt_d  = '0;
                end
                AWR: if (wcnt_q == CW'(WR_CYC-1)) begin
                    state_d = AGAP;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                AGAP: begin
                    state_d = DWR;
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = {hold_q[16], 1'b1};
                    din_d   = hold_q[7:0];
                    wcnt_d  = '0;
                end
                DWR: if (wcnt_q == CW'(WR_CYC-1)) begin
                    state_d = DGAP;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                DGAP: begin
                    state_d  = POLL;
                    cs_d     = 1'b0;
                    addr_d   = 2'd0;
                    pcnt_d   = '0;
                    settle_d = 1'b1;
                end
                POLL: if (settle_q) begin
                    settle_d = 1'b0;
                end else if (!bus.ym_dout[7]) begin
                    state_d = IDLE;
                    cs_d    = 1'b1;
                end else if (pcnt_q == PW'(BUSY_TMO-1)) begin
                    // give up on this entry, keep the queue moving
                    state_d = IDLE;
                    cs_d    = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // sequencer state and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            pcnt_q   <= '0;
            settle_q <= 1'b0;
            hold_q   <= '0;
            cs_q     <= 1'b1;
            wr_q     <= 1'b1;
            addr_q   <= 2'd0;
            din_q    <= 8'd0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            pcnt_q   <= pcnt_d;
            settle_q <= settle_d;
            hold_q   <= hold_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            tmo_q    <= tmo_d;
        end
    end
endmodule

// File: tb/tb_jt12_wr_sched.sv
// Scoreboard bench for jt12_wr_sched: accepted requests are queued as
// expected transactions; a bus monitor reassembles each entry's address
// write, data write and poll window from the pins and compares.
module tb_jt12_wr_sched;
    localparam int AW = 4, DEPTH = 16, WRC = 2, TMO = 255;

    logic clk = 1'b0, rst_n = 1'b1, cen = 1'b0, flush = 1'b0;
    logic [AW:0] level;
    logic active, tmo_err;

    jt12_wr_sched_if bus();

    jt12_wr_sched #(.FIFO_AW(AW), .WR_CYC(WRC), .BUSY_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .flush(flush), .bus(bus),
        .level(level), .active(active), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       part;
        logic [7:0] rg;
        logic [7:0] vl;
        int         busy;   // busy samples the jt12 model reports before ready
    } ent_t;

    ent_t exp_q[$];
    ent_t cur;
    int checks = 0, errors = 0;
    int cyc = 0, cen_mode = 0, push_cyc = 0;

    // monitor state
    bit   mon_en = 0, inflight = 0, tmo_m = 0;
    int   ph_q = 0, mph = 0, len_c = 0, len_k = 0, nwr = 0, n_done = 0;
    int   l0 = 0, l1 = 0, g1 = 0, g2 = 0, l0k = 0, l1k = 0, g1k = 0, g2k = 0, pk = 0;
    int   awr_cyc = 0, end_cyc = 0;
    logic [1:0] cap_a, a0, a1;
    logic [7:0] cap_d, d0, d1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // cen pattern for the cycle just entered
    initial forever begin
        @(posedge clk); #1;
        case (cen_mode)
            0:       cen = 1'b0;
            1:       cen = 1'b1;
            2:       cen = (cyc % 3 == 0);
            default: cen = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic finish_entry();
        int samp;
        samp = (cur.busy + 1 > TMO) ? TMO : cur.busy + 1;
        chk("awr_addr", a0, {cur.part, 1'b0});
        chk("awr_din",  d0, cur.rg);
        chk("awr_len",  l0, WRC);
        chk("agap_len", g1, 1);
        chk("dwr_addr", a1, {cur.part, 1'b1});
        chk("dwr_din",  d1, cur.vl);
        chk("dwr_len",  l1, WRC);
        chk("dgap_len", g2, 1);
        chk("poll_len", len_c, 1 + samp);
        if (cur.busy >= TMO) tmo_m = 1;
        chk("tmo_err", tmo_err, tmo_m);
        pk = len_k; end_cyc = cyc; inflight = 0; nwr = 0; n_done++;
    endtask

    // bus monitor and jt12 busy model, sampled mid-cycle
    always @(negedge clk) begin
        if (!mon_en) begin
            bus.ym_dout = 8'h00;
        end else begin
            mph = bus.ym_cs_n ? 0 : (bus.ym_wr_n ? 2 : 1);
            if (mph != ph_q) begin
                if (ph_q == 1) begin
                    chk("write_then_idle", mph, 0);
                    if (nwr == 0) begin a0 = cap_a; d0 = cap_d; l0 = len_c; l0k = len_k; end
                    else          begin a1 = cap_a; d1 = cap_d; l1 = len_c; l1k = len_k; end
                    nwr++;
                end else if (ph_q == 0) begin
                    if (nwr == 1)      begin g1 = len_c; g1k = len_k; end
                    else if (nwr == 2) begin g2 = len_c; g2k = len_k; end
                    if (mph == 1 && nwr == 0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write: got addr %0d din %0h expected no write", bus.ym_addr, bus.ym_din);
                        end else begin
                            cur = exp_q.pop_front();
                            inflight = 1; awr_cyc = cyc;
                        end
                    end
                    if (mph == 2) chk("poll_after_data", nwr, 2);
                end else begin
                    chk("poll_end_idle", mph, 0);
                    finish_entry();
                end
                len_c = 0; len_k = 0; cap_a = bus.ym_addr; cap_d = bus.ym_din;
            end else if (mph == 1) begin
                chk("wr_addr_stable", bus.ym_addr, cap_a);
                chk("wr_din_stable",  bus.ym_din,  cap_d);
            end
            if (cen) len_c++;
            len_k++;
            ph_q = mph;
            // busy for the first cur.busy sampled cycles after the settle cycle
            if (mph == 2) bus.ym_dout = {(len_c >= 2 && len_c <= cur.busy + 1), 7'($urandom)};
            else          bus.ym_dout = {1'b0, 7'($urandom)};
            chk("level", level, exp_q.size());
            chk("req_ready", bus.req_ready, exp_q.size() < DEPTH);
            chk("active", active, (exp_q.size() != 0) || inflight);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic p, input logic [7:0] r, input logic [7:0] v, input int b);
        ent_t e;
        bit   done;
        done = 0;
        e.part = p; e.rg = r; e.vl = v; e.busy = b;
        bus.req_valid = 1; bus.req_part = p; bus.req_reg = r; bus.req_val = v;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk); done = bus.req_ready;
            @(posedge clk);
            if (done) begin exp_q.push_back(e); push_cyc = cyc; end
            #1;
        end
        bus.req_valid = 0;
        chk("push_accepted", int'(done), 1);
    endtask

    task automatic wait_idle(input int lim, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick(1);
            ok = !active && exp_q.size() == 0 && !inflight;
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic wait_write(input logic a0bit, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick(1);
            ok = !bus.ym_cs_n && !bus.ym_wr_n && bus.ym_addr[0] == a0bit;
        end
        chk(nm, int'(ok), 1);
    endtask

    initial begin
        int nd0;
        bus.req_valid = 0; bus.req_part = 0; bus.req_reg = 0; bus.req_val = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_cs_n", bus.ym_cs_n, 1);
        chk("rst_wr_n", bus.ym_wr_n, 1);
        chk("rst_addr", bus.ym_addr, 0);
        chk("rst_din", bus.ym_din, 0);
        chk("rst_level", level, 0);
        chk("rst_active", active, 0);
        chk("rst_tmo", tmo_err, 0);
        tick(3);
        rst_n = 1; mon_en = 1; cen_mode = 1;
        tick(3);

        // single part-I entry, exact latency
        push(0, 8'h28, 8'hF0, 0);
        wait_idle(100, "t1_idle");
        chk("t1_awr_latency", awr_cyc - push_cyc, 2);
        chk("t1_end_latency", end_cyc - push_cyc, 10);

        // part II addresses
        push(1, 8'hA4, 8'h22, 0);
        wait_idle(100, "t2_idle");
        chk("t2_end_latency", end_cyc - push_cyc, 10);

        // fill to full with the sequencer frozen, then a 17th push
        cen_mode = 0;
        tick(2);
        for (int i = 0; i < 16; i++) push(1'(i), 8'(8'h30 + i), 8'(i * 7), 0);
        @(negedge clk);
        chk("t3_full_level", level, 16);
        chk("t3_full_ready", bus.req_ready, 0);
        tick(1);
        fork
            push(1, 8'hB6, 8'hC0, 0);
            begin tick(5); cen_mode = 1; end
        join
        wait_idle(400, "t3_idle");

        // busy 20 samples, then busy stuck until timeout, then queue continues
        push(0, 8'h22, 8'h08, 20);
        wait_idle(200, "t4a_idle");
        chk("t4_no_tmo", tmo_err, 0);
        push(1, 8'h40, 8'h7F, 300);
        push(0, 8'h41, 8'h11, 0);
        wait_idle(700, "t4b_idle");
        chk("t4_tmo_set", tmo_err, 1);

        // flush during the first data write
        nd0 = n_done;
        for (int i = 0; i < 5; i++) push(0, 8'(8'h50 + i), 8'(i), 0);
        wait_write(1'b1, "t5_dwr_seen");
        flush = 1;
        @(posedge clk);
        exp_q.delete();
        #1 flush = 0;
        wait_idle(100, "t5_idle");
        tick(30);
        chk("t5_level", level, 0);
        chk("t5_done_count", n_done - nd0, 1);

        // randomized traffic with random cen and short busy periods
        cen_mode = 3;
        for (int i = 0; i < 25; i++) begin
            push(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4));
            tick($urandom_range(0, 3));
        end
        wait_idle(5000, "rand_idle");

        // async reset in the middle of an address write
        cen_mode = 1;
        tick(2);
        push(0, 8'h28, 8'h01, 0);
        push(0, 8'h28, 8'h02, 0);
        push(0, 8'h28, 8'h03, 0);
        wait_write(1'b0, "t6_awr_seen");
        #2;
        mon_en = 0;
        rst_n = 0;
        #1;
        chk("t6_cs_n", bus.ym_cs_n, 1);
        chk("t6_wr_n", bus.ym_wr_n, 1);
        chk("t6_level", level, 0);
        chk("t6_active", active, 0);
        chk("t6_tmo", tmo_err, 0);
        exp_q.delete();
        inflight = 0; tmo_m = 0; ph_q = 0; nwr = 0; len_c = 0; len_k = 0;
        tick(2);
        rst_n = 1; mon_en = 1;
        tick(2);

        // cen one-in-three stretches every phase 3x
        cen_mode = 2;
        push(0, 8'h28, 8'hF0, 0);
        wait_idle(200, "t6_cen_idle");
        chk("t6_awr_clk", l0k, 3 * WRC);
        chk("t6_agap_clk", g1k, 3);
        chk("t6_dwr_clk", l1k, 3 * WRC);
        chk("t6_dgap_clk", g2k, 3);
        chk("t6_poll_clk", pk, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
